// File: rtl/fifo_reader_pkg.sv
// Shared types and sizes for the FIFO stream reader.
// Optional burst framing: define FIFO_READER_LAST_EN.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int CNT_W      = 16;

endpackage

// File: rtl/skid_q2.sv
// Two-entry register queue; entry 0 is the head.
// Push into a full queue without a pop never happens upstream.
module skid_q2
  import fifo_reader_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [$clog2(SKID_DEPTH+1)-1:0] occ
);

  logic [W-1:0] e1;

  // Shift/fill the two entries and track occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      e1   <= '0;
      occ  <= '0;
    end else begin
      unique case (1'b1)
        push && pop: begin
          if (occ == 2'd2) begin
            head <= e1;
            e1   <= din;
          end else begin
            head <= din;
          end
        end
        push && !pop: begin
          if (occ == 2'd0) head <= din;
          else             e1   <= din;
          occ <= occ + 2'd1;
        end
        !push && pop: begin
          head <= e1;
          occ  <= occ - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read engine re-presenting words as a valid/ready stream.
// Define FIFO_READER_LAST_EN for m_last burst framing.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DW        = 8,
  parameter int BURST_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [DW-1:0]    fifo_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
`ifdef FIFO_READER_LAST_EN
  output logic             m_last,
`endif
  output logic             busy,
  output logic [CNT_W-1:0] beat_count
);

  state_t     state;
  state_t     state_nx;
  logic       inflight;
  logic [1:0] occ;
  logic       pop;
  logic       issue;
  logic [2:0] credit;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign credit  = {1'b0, occ}
                 + {2'b0, inflight}
                 - {2'b0, pop};

  // Reads stop as soon as enable drops so RUN->IDLE never strands a word.
  assign issue = (state == RUN) && enable
              && !fifo_empty && (credit < 3'd2);
  assign fifo_rd_en = issue;
  assign busy       = (state != IDLE);

`ifdef FIFO_READER_LAST_EN
  localparam logic [CNT_W-1:0] BL_M1 = CNT_W'(BURST_LEN - 1);

  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_nx;
  logic             flush_fin;
  logic [1:0]       ahead;
  logic [CNT_W:0]   idx;
  logic             tag;
  logic             head_last;

  assign flush_fin = (state == FLUSH)
                  && (occ == 2'd1) && !inflight;

  // Burst position after this cycle's pop.
  always_comb begin
    burst_nx = burst_cnt;
    if (pop) begin
      if (burst_cnt == BL_M1 || flush_fin)
        burst_nx = '0;
      else
        burst_nx = burst_cnt + 1'b1;
    end
  end

  // A captured word pops after the entries still ahead of it.
  assign ahead = occ - {1'b0, pop};
  assign idx   = {1'b0, burst_nx} + (CNT_W+1)'(ahead);
  assign tag   = (BURST_LEN == 1)
              || (idx == {1'b0, BL_M1});

  // Burst position register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) burst_cnt <= '0;
    else      burst_cnt <= burst_nx;
  end

  skid_q2 #(.W(DW + 1)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .pop  (pop),
    .din  ({tag, fifo_dout}),
    .head ({head_last, m_data}),
    .occ  (occ)
  );

  assign m_last = m_valid && (head_last || flush_fin);
`else
  skid_q2 #(.W(DW)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .pop  (pop),
    .din  (fifo_dout),
    .head (m_data),
    .occ  (occ)
  );
`endif

  // Read-latency tracker and accepted-beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight   <= 1'b0;
      beat_count <= '0;
    end else begin
      inflight <= issue;
      if (pop) beat_count <= beat_count + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (enable) state_nx = RUN;
      end
      RUN: begin
        if (!enable)
          state_nx = (m_valid || inflight) ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (enable)
          state_nx = RUN;
        else if (!m_valid && !inflight)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
